mm_bram_ctrl: RTL and testbench

MM_BRAM_CTRL -- requirements
Module: mm_bram_ctrl

---
 rtl/mm_bram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mm_bram_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bram_ctrl.sv
// Reads the Montgomery operands from a BRAM, starts the FIOS core, then writes the result back.
// Optional cycle counter for the core run is built only when CYCLE_COUNT_EN is defined.
module mm_bram_ctrl #(
    parameter int WIDTH      = 256,
    parameter int WORD_WIDTH = 17,
    localparam int s         = (WIDTH + 1) / WORD_WIDTH + 1
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    output logic                      done_o,
    output logic                      busy_o,
    output logic [31:0]               bram_addr_o,
    output logic [31:0]               bram_din_o,
    output logic [3:0]                bram_we_o,
    output logic                      bram_en_o,
    input  logic [31:0]               bram_dout_i,
    output logic                      core_start_o,
    input  logic                      core_done_i,
    output logic [WORD_WIDTH-1:0]     p_prime_0_o,
    output logic [s*WORD_WIDTH-1:0]   p_o,
    output logic [s*WORD_WIDTH-1:0]   a_o,
    output logic [s*WORD_WIDTH-1:0]   b_o,
    input  logic [s*WORD_WIDTH-1:0]   res_i,
    output logic [31:0]               cycle_count_o
);

    localparam int IDX_W = $clog2(3 * s + 1);
    localparam int WR_W  = (s > 1) ? $clog2(s) : 1;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, RUN, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]       cap_idx_q, cap_idx_d;
    logic                   cap_vld_q, cap_vld_d;
    logic [WR_W-1:0]        wr_idx_q, wr_idx_d;
    logic                   core_start_q, core_start_d;
    logic [WORD_WIDTH-1:0]  pp0_q, pp0_d;
    logic [WORD_WIDTH-1:0]  p_w_q [s];
    logic [WORD_WIDTH-1:0]  p_w_d [s];
    logic [WORD_WIDTH-1:0]  a_w_q [s];
    logic [WORD_WIDTH-1:0]  a_w_d [s];
    logic [WORD_WIDTH-1:0]  b_w_q [s];
    logic [WORD_WIDTH-1:0]  b_w_d [s];
    logic [WORD_WIDTH-1:0]  res_w_q [s];
    logic [WORD_WIDTH-1:0]  res_w_d [s];
    logic [WORD_WIDTH-1:0]  rd_word;
    logic                   core_finish;
    logic                   unused_dout_bits;

    assign rd_word          = bram_dout_i[WORD_WIDTH-1:0];
    assign unused_dout_bits = ^bram_dout_i[31:WORD_WIDTH];
    // A done seen during the start pulse belongs to the previous run, not this one.
    assign core_finish      = core_done_i && !core_start_q;

    always_comb begin
        state_d      = state_q;
        rd_idx_d     = rd_idx_q;
        cap_idx_d    = rd_idx_q;
        cap_vld_d    = 1'b0;
        wr_idx_d     = wr_idx_q;
        core_start_d = 1'b0;
        pp0_d        = pp0_q;
        p_w_d        = p_w_q;
        a_w_d        = a_w_q;
        b_w_d        = b_w_q;
        res_w_d      = res_w_q;

        // Read data lands one cycle after its address; route it by the delayed index.
        if (cap_vld_q) begin
            if (cap_idx_q == '0) begin
                pp0_d = rd_word;
            end
            for (int i = 0; i < s; i++) begin
                if (cap_idx_q == IDX_W'(i + 1))         p_w_d[i] = rd_word;
                if (cap_idx_q == IDX_W'(i + s + 1))     a_w_d[i] = rd_word;
                if (cap_idx_q == IDX_W'(i + 2 * s + 1)) b_w_d[i] = rd_word;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d  = READ;
                    rd_idx_d = '0;
                end
            end
            READ: begin
                cap_vld_d = 1'b1;
                if (rd_idx_q == IDX_W'(3 * s)) begin
                    state_d = DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                state_d      = RUN;
                core_start_d = 1'b1;
            end
            RUN: begin
                if (core_finish) begin
                    for (int i = 0; i < s; i++) begin
                        res_w_d[i] = res_i[i*WORD_WIDTH +: WORD_WIDTH];
                    end
                    state_d  = WRITE;
                    wr_idx_d = '0;
                end
            end
            WRITE: begin
                if (wr_idx_q == WR_W'(s - 1)) begin
                    state_d = DONE;
                end else begin
                    wr_idx_d = wr_idx_q + WR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != IDLE) && (state_q != DONE);
        done_o       = (state_q == DONE);
        core_start_o = core_start_q;
        bram_en_o    = 1'b0;
        bram_we_o    = 4'h0;
        bram_addr_o  = 32'h0;
        bram_din_o   = 32'h0;
        if (state_q == READ) begin
            bram_en_o   = 1'b1;
            bram_addr_o = {{(30 - IDX_W){1'b0}}, rd_idx_q, 2'b00};
        end else if (state_q == WRITE) begin
            bram_en_o   = 1'b1;
            bram_we_o   = 4'hf;
            bram_addr_o = {{(30 - WR_W){1'b0}}, wr_idx_q, 2'b00};
            bram_din_o  = 32'(res_w_q[wr_idx_q]);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            rd_idx_q     <= '0;
            cap_idx_q    <= '0;
            cap_vld_q    <= 1'b0;
            wr_idx_q     <= '0;
            core_start_q <= 1'b0;
            pp0_q        <= '0;
            p_w_q        <= '{default: '0};
            a_w_q        <= '{default: '0};
            b_w_q        <= '{default: '0};
            res_w_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            rd_idx_q     <= rd_idx_d;
            cap_idx_q    <= cap_idx_d;
            cap_vld_q    <= cap_vld_d;
            wr_idx_q     <= wr_idx_d;
            core_start_q <= core_start_d;
            pp0_q        <= pp0_d;
            p_w_q        <= p_w_d;
            a_w_q        <= a_w_d;
            b_w_q        <= b_w_d;
            res_w_q      <= res_w_d;
        end
    end

    assign p_prime_0_o = pp0_q;
    for (genvar gi = 0; gi < s; gi++) begin : g_pack
        assign p_o[gi*WORD_WIDTH +: WORD_WIDTH] = p_w_q[gi];
        assign a_o[gi*WORD_WIDTH +: WORD_WIDTH] = a_w_q[gi];
        assign b_o[gi*WORD_WIDTH +: WORD_WIDTH] = b_w_q[gi];
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    // Cleared as RUN is entered, so it reads 0 alongside the start pulse.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == DRAIN) begin
            cyc_cnt_d = 32'h0;
        end else if (state_q == RUN && !core_done_i) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cyc_cnt_q <= 32'h0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cycle_count_o = cyc_cnt_q;
`else
    assign cycle_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_mm_bram_ctrl.sv
// Bench for mm_bram_ctrl: BRAM and FIOS-core models, table-driven runs plus randomized runs.
`timescale 1ns/1ps
module tb_mm_bram_ctrl;
    localparam int WW = 17;
    localparam int S  = 16;
    localparam int NW = 3 * S + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_i, start_i, done_o, busy_o, bram_en_o, core_start_o, core_done_i;
    logic [31:0]     bram_addr_o, bram_din_o, bram_dout_i, cycle_count_o;
    logic [3:0]      bram_we_o;
    logic [WW-1:0]   p_prime_0_o;
    logic [S*WW-1:0] p_o, a_o, b_o, res_i;

    mm_bram_ctrl dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .bram_addr_o  (bram_addr_o),
        .bram_din_o   (bram_din_o),
        .bram_we_o    (bram_we_o),
        .bram_en_o    (bram_en_o),
        .bram_dout_i  (bram_dout_i),
        .core_start_o (core_start_o),
        .core_done_i  (core_done_i),
        .p_prime_0_o  (p_prime_0_o),
        .p_o          (p_o),
        .a_o          (a_o),
        .b_o          (b_o),
        .res_i        (res_i),
        .cycle_count_o(cycle_count_o)
    );

    logic [31:0] mem     [64];
    logic [31:0] pre_mem [64];
    logic [31:0] exp_mem [64];
    logic        load_en = 1'b0;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= pre_mem[i];
        end else if (bram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (bram_we_o[b]) mem[bram_addr_o[7:2]][b*8 +: 8] <= bram_din_o[b*8 +: 8];
            bram_dout_i <= mem[bram_addr_o[7:2]];
        end
    end

    int cyc = 0, n_rd = 0, n_wr = 0, n_cs = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bram_en_o && bram_we_o == 4'h0) n_rd++;
        if (bram_en_o && bram_we_o != 4'h0) n_wr++;
        if (core_start_o) n_cs++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_w(input string name, input logic [S*WW-1:0] act, input logic [S*WW-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    typedef struct {
        int delay;
        bit poke_read;
        bit poke_run;
        int rst_wr;
        bit spec_pat;
        int exp_rd;
        int exp_wr;
        int exp_lat;
        int exp_cnt;
        bit exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic run_once(input vec_t v, input string tag);
        logic [S*WW-1:0] rv, exp_p, exp_a, exp_b;
        logic [WW-1:0]   exp_pp0;
        int rd0, wr0, cs0, t0, n, lat, bad, last_wr;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            if (v.spec_pat) pre_mem[i] = (i == 0) ? 32'h11 : (i < NW) ? 32'(i) : $urandom;
            else            pre_mem[i] = (i < S) ? exp_mem[i] : $urandom;
            exp_mem[i] = pre_mem[i];
        end
        exp_pp0 = exp_mem[0][WW-1:0];
        for (int i = 0; i < S; i++) begin
            exp_p[i*WW +: WW] = exp_mem[1 + i][WW-1:0];
            exp_a[i*WW +: WW] = exp_mem[1 + S + i][WW-1:0];
            exp_b[i*WW +: WW] = exp_mem[1 + 2*S + i][WW-1:0];
            rv[i*WW +: WW]    = v.spec_pat ? {WW{1'b1}} : WW'($urandom);
        end
        @(negedge clk) load_en = 1'b1;
        @(negedge clk) load_en = 1'b0;

        rd0 = n_rd; wr0 = n_wr; cs0 = n_cs;
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk) start_i = 1'b0;
        check({tag, " done_after_start"}, done_o, 0);
        check({tag, " busy_after_start"}, busy_o, 1);
        if (v.poke_read) begin
            repeat (9) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk) start_i = 1'b0;
        end

        n = 0;
        while (core_start_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (core_start_o !== 1'b1) begin
            check({tag, " core_start_timeout"}, core_start_o, 1);
            return;
        end
        check({tag, " en_in_run"}, bram_en_o, 0);
        check_w({tag, " b_o"}, b_o, exp_b);

        if (v.delay == 0) begin
            core_done_i = 1'b1;
            res_i = rv;
            @(negedge clk);
            @(negedge clk) core_done_i = 1'b0;
        end else begin
            for (int k = 0; k < v.delay; k++) begin
                @(negedge clk);
                start_i = (v.poke_run && k == 0 && v.delay >= 2);
            end
            start_i = 1'b0;
            core_done_i = 1'b1;
            res_i = rv;
            @(negedge clk) core_done_i = 1'b0;
        end
        for (int i = 0; i < S; i++) res_i[i*WW +: WW] = WW'($urandom);

        last_wr = S - 1;
        if (v.rst_wr >= 0) begin
            repeat (v.rst_wr) @(negedge clk);
            reset_i = 1'b1;
            @(negedge clk) reset_i = 1'b0;
            last_wr = v.rst_wr;
            check({tag, " rst_busy"}, busy_o, 0);
            check({tag, " rst_we"}, bram_we_o, 0);
            check({tag, " rst_pp0"}, p_prime_0_o, 0);
            check_w({tag, " rst_p_o"}, p_o, '0);
            check_w({tag, " rst_a_o"}, a_o, '0);
            repeat (4) @(negedge clk);
        end else begin
            n = 0;
            while (done_o !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            lat = cyc - t0;
            check({tag, " latency"}, lat, v.exp_lat);
            check({tag, " pp0"}, p_prime_0_o, exp_pp0);
            check_w({tag, " p_o"}, p_o, exp_p);
            check_w({tag, " a_o"}, a_o, exp_a);
            check_w({tag, " b_o_hold"}, b_o, exp_b);
            if (v.spec_pat) begin
                check({tag, " pp0_is_11"}, p_prime_0_o, 17'h11);
                check({tag, " p_w0_is_1"}, p_o[WW-1:0], 1);
                check({tag, " a_w0_is_17"}, a_o[WW-1:0], 17);
                check({tag, " b_w15_is_48"}, b_o[15*WW +: WW], 48);
            end
            repeat (3) @(negedge clk);
            check({tag, " busy_in_done"}, busy_o, 0);
            check({tag, " we_in_done"}, bram_we_o, 0);
        end
        check({tag, " done_sticky"}, done_o, v.exp_done);

        for (int i = 0; i <= last_wr; i++) exp_mem[i] = 32'(rv[i*WW +: WW]);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({tag, " mem_words_wrong"}, bad, 0);
        check({tag, " reads"}, n_rd - rd0, v.exp_rd);
        check({tag, " writes"}, n_wr - wr0, v.exp_wr);
        check({tag, " core_starts"}, n_cs - cs0, 1);
`ifdef CYCLE_COUNT_EN
        check({tag, " cycle_count"}, cycle_count_o, v.exp_cnt);
`else
        check({tag, " cycle_count"}, cycle_count_o, 0);
`endif
        $display("[TB] run %s delay=%0d lat=%0d reads=%0d writes=%0d starts=%0d done=%0b cnt=%0d",
                 tag, v.delay, lat, n_rd - rd0, n_wr - wr0, n_cs - cs0, done_o, cycle_count_o);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rvec;
        //          delay rd run rst spec  rd  wr  lat cnt done
        vecs[0] = '{20,   0, 0,  -1, 1,    49, 16, 88, 20, 1};
        vecs[1] = '{7,    1, 1,  -1, 0,    49, 16, 75, 7,  1};
        vecs[2] = '{0,    0, 0,  -1, 0,    49, 16, 69, 0,  1};
        vecs[3] = '{5,    0, 0,  7,  0,    49, 8,  -1, 0,  0};
        vecs[4] = '{1,    0, 0,  -1, 0,    49, 16, 69, 1,  1};
        vecs[5] = '{3,    0, 0,  -1, 0,    49, 16, 71, 3,  1};

        reset_i = 1'b1;
        start_i = 1'b0;
        core_done_i = 1'b0;
        res_i = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("reset done", done_o, 0);
        check("reset busy", busy_o, 0);
        check("reset en", bram_en_o, 0);
        check("reset we", bram_we_o, 0);
        check("reset addr", bram_addr_o, 0);
        check("reset din", bram_din_o, 0);
        check("reset core_start", core_start_o, 0);
        check("reset pp0", p_prime_0_o, 0);
        check("reset cycle_count", cycle_count_o, 0);

        for (int t = 0; t < 6; t++) run_once(vecs[t], $sformatf("vec%0d", t));

        // Reset in the middle of the read phase.
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        repeat (10) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk) reset_i = 1'b0;
        check("midread busy", busy_o, 0);
        check("midread en", bram_en_o, 0);
        check("midread addr", bram_addr_o, 0);
        check_w("midread p_o", p_o, '0);
        $display("[TB] run midread_reset busy=%0b en=%0b", busy_o, bram_en_o);

        for (int r = 0; r < 4; r++) begin
            rvec.delay     = $urandom_range(1, 25);
            rvec.poke_read = 1'($urandom_range(0, 1));
            rvec.poke_run  = 1'($urandom_range(0, 1));
            rvec.rst_wr    = -1;
            rvec.spec_pat  = 1'b0;
            rvec.exp_rd    = NW;
            rvec.exp_wr    = S;
            rvec.exp_lat   = 68 + rvec.delay;
            rvec.exp_cnt   = rvec.delay;
            rvec.exp_done  = 1'b1;
            run_once(rvec, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
